// File: rtl/hall_sensor_emulator.sv
// Three-phase Hall sensor waveform generator with fault injection and a
// signed electrical-step position counter, for sim and bring-up in place of a motor.
module hall_sensor_emulator #(
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned POS_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    dir,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [1:0]              fault,
  output logic [2:0]              h,
  output logic                    step,
  output logic [POS_WIDTH-1:0]    pos,
  output logic                    fault_active
);

  typedef enum logic [2:0] {
    IDX0 = 3'd0,
    IDX1 = 3'd1,
    IDX2 = 3'd2,
    IDX3 = 3'd3,
    IDX4 = 3'd4,
    IDX5 = 3'd5
  } idx_t;

  localparam logic [PERIOD_WIDTH-1:0] CNT_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [POS_WIDTH-1:0]    POS_ONE = {{(POS_WIDTH-1){1'b0}}, 1'b1};

  idx_t                    idx_q, idx_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [POS_WIDTH-1:0]    pos_d;
  logic                    step_d;
  logic [2:0]              h_d;
  logic                    fault_active_d;

  function automatic logic [2:0] hall_code(input idx_t i);
    case (i)
      IDX0:    hall_code = 3'b101;
      IDX1:    hall_code = 3'b100;
      IDX2:    hall_code = 3'b110;
      IDX3:    hall_code = 3'b010;
      IDX4:    hall_code = 3'b011;
      IDX5:    hall_code = 3'b001;
      default: hall_code = 3'b101;
    endcase
  endfunction

  function automatic idx_t idx_fwd(input idx_t i);
    case (i)
      IDX0:    idx_fwd = IDX1;
      IDX1:    idx_fwd = IDX2;
      IDX2:    idx_fwd = IDX3;
      IDX3:    idx_fwd = IDX4;
      IDX4:    idx_fwd = IDX5;
      default: idx_fwd = IDX0;
    endcase
  endfunction

  function automatic idx_t idx_rev(input idx_t i);
    case (i)
      IDX1:    idx_rev = IDX0;
      IDX2:    idx_rev = IDX1;
      IDX3:    idx_rev = IDX2;
      IDX4:    idx_rev = IDX3;
      IDX5:    idx_rev = IDX4;
      default: idx_rev = IDX5;
    endcase
  endfunction

  function automatic logic idx_legal(input idx_t i);
    case (i)
      IDX0, IDX1, IDX2, IDX3, IDX4, IDX5: idx_legal = 1'b1;
      default:                            idx_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    // An out-of-range idx is recovered to IDX0 on any edge, stepping or not.
    idx_d  = idx_legal(idx_q) ? idx_q : IDX0;
    cnt_d  = cnt_q;
    pos_d  = pos;
    step_d = 1'b0;

    if (en) begin
      if (period == '0) begin
        cnt_d = '0;
      end else if (cnt_q >= period - CNT_ONE) begin
        cnt_d  = '0;
        step_d = 1'b1;
        if (dir) begin
          idx_d = idx_legal(idx_q) ? idx_fwd(idx_q) : IDX0;
          pos_d = pos + POS_ONE;
        end else begin
          idx_d = idx_legal(idx_q) ? idx_rev(idx_q) : IDX0;
          pos_d = pos - POS_ONE;
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    fault_active_d = (fault == 2'b01) || (fault == 2'b10);
    case (fault)
      2'b01:   h_d = 3'b000;
      2'b10:   h_d = 3'b111;
      default: h_d = hall_code(idx_d);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= IDX0;
      cnt_q        <= '0;
      pos          <= '0;
      step         <= 1'b0;
      h            <= 3'b101;
      fault_active <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pos          <= pos_d;
      step         <= step_d;
      h            <= h_d;
      fault_active <= fault_active_d;
    end
  end

endmodule

// File: tb/tb_hall_sensor_emulator.sv
// Directed bench for hall_sensor_emulator: cycle model checked every edge
// plus literal expectations at the interesting points.
module tb_hall_sensor_emulator;
  localparam int PW = 16;
  localparam int QW = 16;

  logic          clk = 1'b0;
  logic          rst, en, dir;
  logic [PW-1:0] period;
  logic [1:0]    fault;
  logic [2:0]    h;
  logic          step;
  logic [QW-1:0] pos;
  logic          fault_active;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hall_sensor_emulator #(.PERIOD_WIDTH(PW), .POS_WIDTH(QW)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .period(period), .fault(fault),
    .h(h), .step(step), .pos(pos), .fault_active(fault_active)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: sequence position as an integer mod 6, position as a plain int.
  bit [2:0] tbl [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  int       m_idx = 0, m_cnt = 0, m_pos = 0;
  bit       m_step = 0, m_fa = 0, armed = 0;
  bit [2:0] m_h = 3'b101;
  logic [15:0] m_pos16;

  always @(posedge clk) begin
    if (rst) begin
      m_idx = 0; m_cnt = 0; m_pos = 0; m_step = 0; armed = 1;
    end else begin
      m_step = 0;
      if (en) begin
        if (period == 0) m_cnt = 0;
        else if (m_cnt + 1 >= int'(period)) begin
          m_cnt  = 0;
          m_step = 1;
          if (dir) begin m_idx = (m_idx + 1) % 6; m_pos = m_pos + 1; end
          else     begin m_idx = (m_idx + 5) % 6; m_pos = m_pos - 1; end
        end else m_cnt = m_cnt + 1;
      end
    end
    m_fa = !rst && (fault == 2'b01 || fault == 2'b10);
    if (rst)                 m_h = 3'b101;
    else if (fault == 2'b01) m_h = 3'b000;
    else if (fault == 2'b10) m_h = 3'b111;
    else                     m_h = tbl[m_idx];
    m_pos16 = m_pos[15:0];
    #1;
    if (armed) begin
      chk("model_h",     32'(h),            32'(m_h));
      chk("model_step",  32'(step),         32'(m_step));
      chk("model_pos",   32'(pos),          32'(m_pos16));
      chk("model_fault", 32'(fault_active), 32'(m_fa));
    end
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; dir = 1'b1; period = 16'd4; fault = 2'b00;

    // Reset held 3 edges
    edges(3);
    chk("rst_h",    32'(h),            32'h5);
    chk("rst_pos",  32'(pos),          32'h0);
    chk("rst_step", 32'(step),         32'h0);
    chk("rst_fa",   32'(fault_active), 32'h0);
    rst = 1'b0;
    edges(3);
    chk("pre_step",  32'(step), 32'h0);
    chk("pre_h",     32'(h),    32'h5);
    edges(1);
    chk("first_h",    32'(h),    32'h4);
    chk("first_step", 32'(step), 32'h1);
    edges(1);
    chk("first_step_end", 32'(step), 32'h0);

    // Forward run to 14 steps
    edges(51);
    chk("fwd_pos", 32'(pos), 32'd14);
    chk("fwd_h",   32'(h),   32'h6);

    // Reverse and direction change
    pulse_reset();
    dir = 1'b1; period = 16'd4;
    edges(12);
    chk("rev_pos3", 32'(pos), 32'd3);
    chk("rev_h3",   32'(h),   32'h2);
    edges(2);
    dir = 1'b0;
    edges(1);
    chk("dirchg_nostep", 32'(step), 32'h0);
    edges(1);
    chk("dirchg_step", 32'(step), 32'h1);
    chk("dirchg_h",    32'(h),    32'h6);
    chk("dirchg_pos",  32'(pos),  32'd2);
    edges(12);
    chk("rev_pos_m1", 32'(pos), 32'hFFFF);
    chk("rev_h_m1",   32'(h),   32'h1);
    edges(4);
    chk("rev_pos_m2", 32'(pos), 32'hFFFE);
    chk("rev_h_m2",   32'(h),   32'h3);

    // period=1 steps every cycle
    period = 16'd1;
    for (int i = 0; i < 6; i++) begin
      edges(1);
      chk("p1_step", 32'(step), 32'h1);
    end
    chk("p1_pos", 32'(pos), 32'hFFF8);
    // period=0 mid-interval holds
    period = 16'd4;
    edges(2);
    period = 16'd0;
    for (int i = 0; i < 3; i++) begin
      edges(1);
      chk("p0_step", 32'(step), 32'h0);
      chk("p0_pos",  32'(pos),  32'hFFF8);
    end
    period = 16'd3;
    edges(2);
    chk("p3_wait", 32'(step), 32'h0);
    edges(1);
    chk("p3_step", 32'(step), 32'h1);
    chk("p3_pos",  32'(pos),  32'hFFF7);
    period = 16'd10;
    edges(5);
    period = 16'd2;
    edges(1);
    chk("pdrop_step", 32'(step), 32'h1);
    chk("pdrop_pos",  32'(pos),  32'hFFF6);

    // Fault injection
    pulse_reset();
    dir = 1'b1; period = 16'd8;
    edges(3);
    fault = 2'b01;
    edges(1);
    chk("f01_h",  32'(h),            32'h0);
    chk("f01_fa", 32'(fault_active), 32'h1);
    edges(19);
    chk("f01_pos", 32'(pos), 32'd2);
    fault = 2'b00;
    edges(1);
    chk("f01_rel_h",  32'(h),            32'h2);
    chk("f01_rel_fa", 32'(fault_active), 32'h0);
    chk("f01_rel_pos", 32'(pos),         32'd3);
    fault = 2'b10;
    edges(20);
    chk("f10_h",   32'(h),            32'h7);
    chk("f10_fa",  32'(fault_active), 32'h1);
    chk("f10_pos", 32'(pos),          32'd5);
    fault = 2'b11;
    edges(1);
    chk("f11_h",  32'(h),            32'h1);
    chk("f11_fa", 32'(fault_active), 32'h0);
    fault = 2'b00;

    // Position wrap
    pulse_reset();
    period = 16'd1; dir = 1'b1;
    edges(32767);
    chk("wrap_max", 32'(pos), 32'h7FFF);
    edges(1);
    chk("wrap_min", 32'(pos), 32'h8000);

    // en freeze at cnt=2
    period = 16'd4;
    edges(2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edges(1);
      chk("en_off_step", 32'(step), 32'h0);
      chk("en_off_pos",  32'(pos),  32'h8000);
    end
    en = 1'b1;
    edges(1);
    chk("en_resume_wait", 32'(step), 32'h0);
    edges(1);
    chk("en_resume_step", 32'(step), 32'h1);
    chk("en_resume_pos",  32'(pos),  32'h8001);

    edges(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
